// File: rtl/cla_pkg.sv
// cla_pkg: shared definitions for the pipelined carry-lookahead adder.
//   op_t                 - operation codes carried on in_op
//   GROUP                - bits per lookahead group
//   group_p / group_g    - group propagate / generate from bit-level p and g
//   group_carries        - carry into each bit of a group, seeded by cin
package cla_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_ADDC = 2'd2,
    OP_RSVD = 2'd3
  } op_t;

  localparam int GROUP = 4;

  function automatic logic group_p(input logic [3:0] p);
    return &p;
  endfunction

  function automatic logic group_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Two-level lookahead: every carry is a flat sum of products of g, p and cin,
  // so no carry waits on its neighbour inside the group.
  function automatic logic [3:0] group_carries(input logic [3:0] g, input logic [3:0] p,
                                               input logic cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead slice.
//   a, b   in  4  operand bits (b already inverted for subtraction)
//   cin    in  1  carry into bit 0 of the group
//   sum    out 4  a + b + cin, low four bits
//   grp_p  out 1  group propagate
//   grp_g  out 1  group generate
//   cout   out 1  carry out of bit 3
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       grp_p,
  output logic       grp_g,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g     = a & b;
  assign p     = a | b;
  assign c     = group_carries(g, p, cin);
  assign sum   = a ^ b ^ c;
  assign grp_p = group_p(p);
  assign grp_g = group_g(g, p);
  assign cout  = grp_g | (grp_p & cin);

endmodule

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined carry-lookahead adder/subtractor with
// valid/ready handshakes on both sides, one operation per cycle.
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid/in_ready   operand handshake
//   in_a, in_b          operands (WIDTH bits)
//   in_op               ADD=0, SUB=1, ADDC=2, 3 behaves as ADD
//   in_cin              carry-in, only used by ADDC
//   out_valid/out_ready result handshake
//   out_sum             (a + b' + c0) mod 2^WIDTH
//   out_cout            carry out of the MSB (for SUB: 1 = no borrow)
//   out_ovf             two's-complement signed overflow
// Stage 1 forms the effective operands and bit/group propagate-generate terms;
// stage 2 resolves group carries and produces sum and flags.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NG = WIDTH / GROUP;

  if (((WIDTH % GROUP) != 0) || (WIDTH < GROUP)) begin : g_width_check
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 and at least 4");
  end

  // Handshake and stage enables. A stage may load when it is empty or when
  // the stage after it is moving; in_ready is therefore combinational from
  // out_ready (no skid buffer).
  logic s1_valid;
  logic s2_valid;
  logic s1_en;
  logic s2_en;

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  // Operand conditioning: subtraction is a + ~b + 1, ADDC takes the external
  // carry, and the reserved code falls through to plain ADD.
  op_t              op;
  logic [WIDTH-1:0] b_eff;
  logic             c0_eff;
  logic [WIDTH-1:0] g_eff;
  logic [WIDTH-1:0] p_eff;
  logic [NG-1:0]    gp_eff;
  logic [NG-1:0]    gg_eff;

  always_comb begin
    op     = op_t'(in_op);
    b_eff  = in_b;
    c0_eff = 1'b0;
    case (op)
      OP_SUB: begin
        b_eff  = ~in_b;
        c0_eff = 1'b1;
      end
      OP_ADDC: c0_eff = in_cin;
      default: ;
    endcase
    g_eff = in_a & b_eff;
    p_eff = in_a | b_eff;
    for (int k = 0; k < NG; k++) begin
      gp_eff[k] = group_p(p_eff[k*GROUP +: GROUP]);
      gg_eff[k] = group_g(g_eff[k*GROUP +: GROUP], p_eff[k*GROUP +: GROUP]);
    end
  end

  // Stage 1 register bank. Data only loads with a real beat so the bank
  // holds its last contents while idle.
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_c0;
  logic [WIDTH-1:0] s1_g;
  logic [WIDTH-1:0] s1_p;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c0    <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_gp    <= '0;
      s1_gg    <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= b_eff;
        s1_c0 <= c0_eff;
        s1_g  <= g_eff;
        s1_p  <= p_eff;
        s1_gp <= gp_eff;
        s1_gg <= gg_eff;
      end
    end
  end

  // Group-level carries from the registered group P/G, seeded by c0.
  logic [NG:0] grp_c;

  always_comb begin
    grp_c[0] = s1_c0;
    for (int k = 0; k < NG; k++) begin
      grp_c[k+1] = s1_gg[k] | (s1_gp[k] & grp_c[k]);
    end
  end

  logic [WIDTH-1:0] s2_sum;
  logic [NG-1:0]    inst_p;
  logic [NG-1:0]    inst_g;
  logic [NG-1:0]    inst_cout;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .a     (s1_a[k*GROUP +: GROUP]),
      .b     (s1_b[k*GROUP +: GROUP]),
      .cin   (grp_c[k]),
      .sum   (s2_sum[k*GROUP +: GROUP]),
      .grp_p (inst_p[k]),
      .grp_g (inst_g[k]),
      .cout  (inst_cout[k])
    );
  end

  // Carry into the MSB is recovered from its half-sum (p & ~g == a ^ b')
  // and the sum bit, avoiding a separate carry tap inside the top group.
  logic cout_next;
  logic msb_cin;
  logic ovf_next;

  assign cout_next = inst_cout[NG-1];
  assign msb_cin   = (s1_p[WIDTH-1] & ~s1_g[WIDTH-1]) ^ s2_sum[WIDTH-1];
  assign ovf_next  = msb_cin ^ cout_next;

  // Stage 2 register bank, which is also the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sum  <= s2_sum;
        out_cout <= cout_next;
        out_ovf  <= ovf_next;
      end
    end
  end

  // Consistency between the stage-1 terms and what the stage-2 slices
  // recompute from the same registered operands.
  a_grp_consistent : assert property (@(posedge clk) disable iff (!rst_n)
    (inst_p == s1_gp) && (inst_g == s1_gg) && (inst_cout == grp_c[NG:1]));

  a_bit_terms : assert property (@(posedge clk) disable iff (!rst_n)
    (s1_g == (s1_a & s1_b)) && (s1_p == (s1_a | s1_b)));

endmodule
